// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default framing parameters.
package uart_pkg;

    localparam int unsigned DEF_DIVISOR    = 27;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte output port of the UART receiver: valid/ready handshake plus error pulses.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/baud_tick.sv
// Restartable clock divider producing a one-cycle oversample tick every DIVISOR clocks.
module baud_tick #(
    parameter int unsigned DIVISOR = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    // Next count: wraps at DIVISOR-1, forced to zero on restart.
    always_comb begin
        cnt_n = '0;
        if (!restart && (cnt != CW'(DIVISOR - 1))) begin
            cnt_n = cnt + CW'(1);
        end
    end

    // Tick is registered one cycle ahead so it is high while cnt sits at DIVISOR-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            tick <= (cnt_n == CW'(DIVISOR - 1));
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop recovery with a one-entry output holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR    = DEF_DIVISOR,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int unsigned SW   = $clog2(OVERSAMPLE);
    localparam int unsigned BW   = $clog2(DATA_BITS);
    localparam int unsigned HALF = OVERSAMPLE / 2;

    logic                 rx_meta;
    logic                 rxs;
    rx_state_t            state;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           settle;
    logic                 tick;
    logic                 restart_c;
    logic                 sample_c;

    // Divider and sample counter are held at zero until a start edge is seen.
    assign restart_c = (state == ST_IDLE) || (state == ST_BREAK);

    // Sample point: mid start bit in START, then one full bit period apart.
    assign sample_c = tick && (scnt == ((state == ST_START) ? SW'(HALF - 1) : SW'(OVERSAMPLE - 1)));

    baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_c),
        .tick    (tick)
    );

    // Two-flop synchronizer on the asynchronous line, idle-high after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM, sample counter, shift register and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            scnt          <= '0;
            bitcnt        <= '0;
            shreg         <= '0;
            settle        <= 2'd3;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;

            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (restart_c) begin
                scnt <= '0;
            end else if (tick) begin
                scnt <= sample_c ? '0 : scnt + SW'(1);
            end

            case (state)
                // After reset, wait for the synchronizer to carry a real line value;
                // a line still low at that point is a break, not a start bit.
                ST_IDLE: begin
                    if (settle != 2'd0) begin
                        settle <= settle - 2'd1;
                        if ((settle == 2'd1) && !rxs) begin
                            state <= ST_BREAK;
                        end
                    end else if (!rxs) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (sample_c) begin
                        state <= rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_c) begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bitcnt == BW'(DATA_BITS - 1)) begin
                            bitcnt <= '0;
                            state  <= ST_STOP;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (sample_c) begin
                        if (rxs) begin
                            state <= ST_IDLE;
                            if (!bus.out_valid || bus.out_ready) begin
                                bus.out_data  <= shreg;
                                bus.out_valid <= 1'b1;
                            end else begin
                                bus.overrun <= 1'b1;
                            end
                        end else begin
                            state         <= ST_BREAK;
                            bus.frame_err <= 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with DIVISOR=4, OVERSAMPLE=16, DATA_BITS=8.
module tb_uart_rx;
    localparam int BIT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DIVISOR    (4),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Observed behaviour, written only by the monitor.
    logic [7:0] got_q[$];
    int         total_ferr = 0;
    int         total_ovr  = 0;
    int         hold_viol  = 0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    // Monitor: accepted bytes, flag pulses, and data stability while held.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            if (bus.frame_err) total_ferr++;
            if (bus.overrun) total_ovr++;
            if (prev_v && !prev_r && (!bus.out_valid || (bus.out_data != prev_d))) hold_viol++;
        end
        prev_v = bus.out_valid;
        prev_r = bus.out_ready;
        prev_d = bus.out_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        step(n);
    endtask

    // Start bit, LSB-first data, then one stop bit of the given level.
    task automatic send_frame(input logic [7:0] d, input logic stopv, input int bl);
        hold(1'b0, bl);
        for (int i = 0; i < 8; i++) hold(d[i], bl);
        hold(stopv, bl);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopv;
        int         bl;
        logic       exp_ok;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         exp_ferr;
    int         base_g, base_f, base_o;
    logic [7:0] rd;
    logic       rs;
    int         rbl;
    logic       rnd_done;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 64, 1'b1, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 62, 1'b1, 8'hFF};
        vecs[2] = '{8'h01, 1'b1, 66, 1'b1, 8'h01};
        vecs[3] = '{8'h80, 1'b1, 63, 1'b1, 8'h80};
        vecs[4] = '{8'h5A, 1'b0, 64, 1'b0, 8'h00};
        vecs[5] = '{8'hC7, 1'b1, 65, 1'b1, 8'hC7};

        bus.out_ready = 1'b0;
        rst = 1'b1;
        rx  = 1'b1;
        step(4);

        // Reset state.
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);

        // Line low at reset release must not be taken as a start bit.
        step(1);
        rx = 1'b0;
        step(2);
        base_g = got_q.size();
        base_f = total_ferr;
        rst = 1'b0;
        hold(1'b0, 200);
        hold(1'b1, 700);
        check("rstlow_bytes", 32'(got_q.size() - base_g), 32'd0);
        check("rstlow_ferr", 32'(total_ferr - base_f), 32'd0);

        // Single byte with exact latency.
        bus.out_ready = 1'b1;
        base_f = total_ferr;
        base_o = total_ovr;
        fork
            send_frame(8'hA5, 1'b1, BIT);
            begin
                repeat (610) @(posedge clk);
                @(negedge clk);
                check("single_early", 32'(bus.out_valid), 32'd0);
                @(negedge clk);
                check("single_valid", 32'(bus.out_valid), 32'd1);
                check("single_data", 32'(bus.out_data), 32'hA5);
                @(negedge clk);
                check("single_clear", 32'(bus.out_valid), 32'd0);
            end
        join
        hold(1'b1, 20);
        check("single_flags", 32'((total_ferr - base_f) + (total_ovr - base_o)), 32'd0);

        // Table of frames, including rate offsets and a bad stop bit.
        for (int v = 0; v < 6; v++) begin
            base_g = got_q.size();
            base_f = total_ferr;
            send_frame(vecs[v].data, vecs[v].stopv, vecs[v].bl);
            if (!vecs[v].stopv) hold(1'b0, BIT);
            hold(1'b1, 20);
            check($sformatf("vec%0d_count", v), 32'(got_q.size() - base_g), 32'(vecs[v].exp_ok));
            if (vecs[v].exp_ok && (got_q.size() > base_g))
                check($sformatf("vec%0d_data", v), 32'(got_q[base_g]), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_ferr", v), 32'(total_ferr - base_f), 32'(!vecs[v].exp_ok));
        end

        // Back-to-back with backpressure: second byte is dropped.
        bus.out_ready = 1'b0;
        base_g = got_q.size();
        base_o = total_ovr;
        send_frame(8'h3C, 1'b1, BIT);
        send_frame(8'hC3, 1'b1, BIT);
        hold(1'b1, 20);
        @(negedge clk);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        check("bp_data", 32'(bus.out_data), 32'h3C);
        check("bp_overrun", 32'(total_ovr - base_o), 32'd1);
        step(1);
        bus.out_ready = 1'b1;
        step(1);
        @(negedge clk);
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        check("bp_count", 32'(got_q.size() - base_g), 32'd1);
        if (got_q.size() > base_g) check("bp_byte", 32'(got_q[base_g]), 32'h3C);
        step(1);

        // Accept and load in the same cycle.
        bus.out_ready = 1'b0;
        base_g = got_q.size();
        base_o = total_ovr;
        fork
            begin
                send_frame(8'h3C, 1'b1, BIT);
                send_frame(8'hC3, 1'b1, BIT);
            end
            begin
                repeat (1250) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                check("sim_pre", 32'(bus.out_data), 32'h3C);
                @(negedge clk);
                check("sim_valid", 32'(bus.out_valid), 32'd1);
                check("sim_data", 32'(bus.out_data), 32'hC3);
                check("sim_ovr_pin", 32'(bus.overrun), 32'd0);
            end
        join
        hold(1'b1, 20);
        check("sim_ovr", 32'(total_ovr - base_o), 32'd0);
        check("sim_count", 32'(got_q.size() - base_g), 32'd2);
        if (got_q.size() >= base_g + 2) check("sim_second", 32'(got_q[base_g + 1]), 32'hC3);

        // Framing error followed by a long break, then a good frame.
        base_g = got_q.size();
        base_f = total_ferr;
        send_frame(8'h55, 1'b0, BIT);
        hold(1'b0, 3 * BIT);
        check("brk_nobyte", 32'(got_q.size() - base_g), 32'd0);
        hold(1'b1, BIT);
        send_frame(8'h81, 1'b1, BIT);
        hold(1'b1, 20);
        check("brk_ferr", 32'(total_ferr - base_f), 32'd1);
        check("brk_count", 32'(got_q.size() - base_g), 32'd1);
        if (got_q.size() > base_g) check("brk_byte", 32'(got_q[base_g]), 32'h81);

        // Glitch shorter than half a bit.
        base_g = got_q.size();
        base_f = total_ferr;
        hold(1'b0, 20);
        hold(1'b1, 2 * BIT);
        check("glitch_bytes", 32'(got_q.size() - base_g), 32'd0);
        check("glitch_ferr", 32'(total_ferr - base_f), 32'd0);
        send_frame(8'hFF, 1'b1, BIT);
        hold(1'b1, 20);
        check("glitch_next", 32'(got_q.size() - base_g), 32'd1);
        if (got_q.size() > base_g) check("glitch_byte", 32'(got_q[base_g]), 32'hFF);

        // Reset in the middle of data bit 4.
        base_g = got_q.size();
        base_f = total_ferr;
        fork
            send_frame(8'h0F, 1'b1, BIT);
            begin
                repeat (5 * BIT + BIT / 2) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("mid_valid", 32'(bus.out_valid), 32'd0);
                check("mid_data", 32'(bus.out_data), 32'd0);
                check("mid_flags", 32'({bus.frame_err, bus.overrun}), 32'd0);
            end
        join
        hold(1'b1, BIT);
        check("mid_nobyte", 32'(got_q.size() - base_g), 32'd0);
        check("mid_noferr", 32'(total_ferr - base_f), 32'd0);
        send_frame(8'h42, 1'b1, BIT);
        hold(1'b1, 20);
        check("mid_next", 32'(got_q.size() - base_g), 32'd1);
        if (got_q.size() > base_g) check("mid_byte", 32'(got_q[base_g]), 32'h42);

        // Random frames, rates, gaps and consumer stalls against a byte-list model.
        base_g = got_q.size();
        base_f = total_ferr;
        base_o = total_ovr;
        exp_ferr = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    rd  = 8'($urandom);
                    rs  = ($urandom_range(0, 5) != 0);
                    rbl = $urandom_range(62, 66);
                    send_frame(rd, rs, rbl);
                    if (rs) exp_q.push_back(rd);
                    else begin
                        exp_ferr++;
                        hold(1'b0, $urandom_range(0, 100));
                    end
                    hold(1'b1, $urandom_range(2, 30));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        hold(1'b1, 20);
        check("rnd_count", 32'(got_q.size() - base_g), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_g + i < got_q.size())
                check($sformatf("rnd_byte%0d", i), 32'(got_q[base_g + i]), 32'(exp_q[i]));
        end
        check("rnd_ferr", 32'(total_ferr - base_f), 32'(exp_ferr));
        check("rnd_ovr", 32'(total_ovr - base_o), 32'd0);
        check("hold_stable", 32'(hold_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
